// File: rtl/bias_requant_pkg.sv
// Shared widths and helpers for the bias-add / requantise pipeline.
// Module parameters default to the constants here; derived widths come from the helper functions.
package bias_requant_pkg;

    localparam int X_PE_DEF         = 16;
    localparam int BIAS_DATALEN_DEF = 20;
    localparam int ACC_LEN_DEF      = 20;
    localparam int OUT_LEN_DEF      = 8;
    localparam int SATCNT_LEN_DEF   = 16;
    localparam int SHIFT_LEN        = 5;

    // One extra bit over the wider operand so psum + bias can never overflow.
    function automatic int sum_width(input int acc_len, input int bias_len);
        return ((acc_len > bias_len) ? acc_len : bias_len) + 1;
    endfunction

    // One more bit for the rounding increment.
    function automatic int shift_width(input int acc_len, input int bias_len);
        return sum_width(acc_len, bias_len) + 1;
    endfunction

    localparam int SUM_W_DEF   = sum_width(ACC_LEN_DEF, BIAS_DATALEN_DEF);
    localparam int SHF_W_DEF   = shift_width(ACC_LEN_DEF, BIAS_DATALEN_DEF);
    localparam int OUT_MAX_DEF = (2 ** (OUT_LEN_DEF - 1)) - 1;
    localparam int OUT_MIN_DEF = -(2 ** (OUT_LEN_DEF - 1));

    typedef struct packed {
        logic [SHIFT_LEN-1:0] shift;
        logic                 relu;
    } beat_cfg_t;

endpackage

// File: rtl/requant_lane.sv
// One lane: bias add, round-half-up arithmetic shift, signed saturation and optional ReLU.
// Stage load enables and per-beat config come from the shared valid/config pipe in the top level.
module requant_lane
    import bias_requant_pkg::*;
#(
    parameter int BIAS_DATALEN = BIAS_DATALEN_DEF,
    parameter int ACC_LEN      = ACC_LEN_DEF,
    parameter int OUT_LEN      = OUT_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ACC_LEN-1:0]      psum_i,
    input  logic [BIAS_DATALEN-1:0] bias_i,
    input  logic                    ld1_i,
    input  logic                    ld2_i,
    input  logic                    ld3_i,
    input  logic [SHIFT_LEN-1:0]    shift_i,
    input  logic                    relu_i,
    output logic [OUT_LEN-1:0]      data_o,
    output logic                    clip_o
);

    localparam int SUM_W = sum_width(ACC_LEN, BIAS_DATALEN);
    localparam int SHF_W = shift_width(ACC_LEN, BIAS_DATALEN);

    localparam logic signed [SHF_W-1:0] SAT_MAX =
        {{(SHF_W - OUT_LEN + 1){1'b0}}, {(OUT_LEN - 1){1'b1}}};
    localparam logic signed [SHF_W-1:0] SAT_MIN =
        {{(SHF_W - OUT_LEN + 1){1'b1}}, {(OUT_LEN - 1){1'b0}}};

    logic signed [SUM_W-1:0] s1_d, s1_q;
    logic signed [SHF_W-1:0] s1_ext, pre_sh, rnd_sum;
    logic signed [SHF_W-1:0] s2_d, s2_q;
    logic [OUT_LEN-1:0]      out_d, out_q;
    logic                    clip;

    always_comb begin
        s1_d = {{(SUM_W - ACC_LEN){psum_i[ACC_LEN-1]}}, psum_i}
             + {{(SUM_W - BIAS_DATALEN){bias_i[BIAS_DATALEN-1]}}, bias_i};
    end

    // (s + 2^(k-1)) >>> k computed as ((s >>> (k-1)) + 1) >>> 1: identical result, but the
    // rounding constant never has to be represented, so shifts beyond the datapath width stay exact.
    always_comb begin
        s1_ext  = {s1_q[SUM_W-1], s1_q};
        pre_sh  = s1_ext >>> (shift_i - 5'd1);
        rnd_sum = pre_sh + SHF_W'(1);
        if (shift_i == '0) begin
            s2_d = s1_ext;
        end else begin
            s2_d = rnd_sum >>> 1;
        end
    end

    // ReLU follows saturation, so a lane clipped to the negative bound still reports a clip.
    always_comb begin
        clip  = 1'b0;
        out_d = s2_q[OUT_LEN-1:0];
        if (s2_q > SAT_MAX) begin
            clip  = 1'b1;
            out_d = SAT_MAX[OUT_LEN-1:0];
        end else if (s2_q < SAT_MIN) begin
            clip  = 1'b1;
            out_d = SAT_MIN[OUT_LEN-1:0];
        end
        if (relu_i && out_d[OUT_LEN-1]) begin
            out_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            out_q <= '0;
        end else begin
            if (ld1_i) s1_q  <= s1_d;
            if (ld2_i) s2_q  <= s2_d;
            if (ld3_i) out_q <= out_d;
        end
    end

    assign data_o = out_q;
    assign clip_o = clip;

endmodule

// File: rtl/bias_requant.sv
// Bias register, valid/config pipe and saturation counter around X_PE requant lanes.
// Fixed 3-cycle latency, no backpressure; data_valid is a delayed copy of psum_valid.
module bias_requant
    import bias_requant_pkg::*;
#(
    parameter int X_PE         = X_PE_DEF,
    parameter int BIAS_DATALEN = BIAS_DATALEN_DEF,
    parameter int ACC_LEN      = ACC_LEN_DEF,
    parameter int OUT_LEN      = OUT_LEN_DEF,
    parameter int SATCNT_LEN   = SATCNT_LEN_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [X_PE*BIAS_DATALEN-1:0] bias_in,
    input  logic                         bias_en,
    input  logic [X_PE*ACC_LEN-1:0]      psum_in,
    input  logic                         psum_valid,
    input  logic [SHIFT_LEN-1:0]         out_shift,
    input  logic                         relu_en,
    output logic [X_PE*OUT_LEN-1:0]      data_out,
    output logic                         data_valid,
    output logic [SATCNT_LEN-1:0]        sat_count,
    output logic                         idle
);

    localparam int CNT_W = $clog2(X_PE + 1);

    logic [X_PE*BIAS_DATALEN-1:0] bias_d, bias_q;
    logic [2:0]                   vld_d, vld_q;
    beat_cfg_t                    cfg1_d, cfg1_q, cfg2_d, cfg2_q;
    logic [X_PE-1:0]              clip;
    logic [CNT_W-1:0]             clip_cnt;
    logic [SATCNT_LEN-1:0]        sat_base, sat_d, sat_q;
    logic [SATCNT_LEN:0]          sat_sum;

    // A beat coincident with bias_en still sees the old bias: bias_q only changes at the edge.
    always_comb begin
        bias_d = bias_en ? bias_in : bias_q;
        vld_d  = {vld_q[1:0], psum_valid};
        cfg1_d = psum_valid ? '{shift: out_shift, relu: relu_en} : cfg1_q;
        cfg2_d = vld_q[0] ? cfg1_q : cfg2_q;
    end

    always_comb begin
        clip_cnt = '0;
        for (int j = 0; j < X_PE; j++) begin
            clip_cnt = clip_cnt + CNT_W'(clip[j]);
        end
    end

    // Clear and increment in one cycle yields just that cycle's increment; no wrap.
    always_comb begin
        sat_base = bias_en ? '0 : sat_q;
        sat_sum  = {1'b0, sat_base} + (vld_q[1] ? (SATCNT_LEN + 1)'(clip_cnt) : '0);
        sat_d    = sat_sum[SATCNT_LEN] ? '1 : sat_sum[SATCNT_LEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bias_q <= '0;
            vld_q  <= '0;
            cfg1_q <= '0;
            cfg2_q <= '0;
            sat_q  <= '0;
        end else begin
            bias_q <= bias_d;
            vld_q  <= vld_d;
            cfg1_q <= cfg1_d;
            cfg2_q <= cfg2_d;
            sat_q  <= sat_d;
        end
    end

    for (genvar j = 0; j < X_PE; j++) begin : g_lane
        requant_lane #(
            .BIAS_DATALEN (BIAS_DATALEN),
            .ACC_LEN      (ACC_LEN),
            .OUT_LEN      (OUT_LEN)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .psum_i  (psum_in[j*ACC_LEN +: ACC_LEN]),
            .bias_i  (bias_q[j*BIAS_DATALEN +: BIAS_DATALEN]),
            .ld1_i   (psum_valid),
            .ld2_i   (vld_q[0]),
            .ld3_i   (vld_q[1]),
            .shift_i (cfg1_q.shift),
            .relu_i  (cfg2_q.relu),
            .data_o  (data_out[j*OUT_LEN +: OUT_LEN]),
            .clip_o  (clip[j])
        );
    end

    assign data_valid = vld_q[2];
    assign sat_count  = sat_q;
    assign idle       = ~|vld_q;

endmodule

// File: tb/tb_bias_requant.sv
// Self-checking bench for bias_requant: constant vector table, hand-written corner sequences
// and random traffic, all compared against a latency-keyed arithmetic reference model.
module tb_bias_requant;

    localparam int X  = 16;
    localparam int BL = 20;
    localparam int AL = 20;
    localparam int OL = 8;
    localparam int SL = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [X*BL-1:0]   bias_in;
    logic              bias_en;
    logic [X*AL-1:0]   psum_in;
    logic              psum_valid;
    logic [4:0]        out_shift;
    logic              relu_en;
    logic [X*OL-1:0]   data_out;
    logic              data_valid;
    logic [SL-1:0]     sat_count;
    logic              idle;

    bias_requant dut (
        .clk        (clk),
        .rst        (rst),
        .bias_in    (bias_in),
        .bias_en    (bias_en),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .out_shift  (out_shift),
        .relu_en    (relu_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sat_count  (sat_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bias;
        int psum;
        int shift;
        bit relu;
        int exp;
        int sat;
    } vec_t;

    typedef struct {
        logic [X*OL-1:0] data;
        int              clips;
    } res_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int dv_seen = 0;

    int b_drv[X];
    int p_drv[X];
    int bias_m[X];
    res_t pend[int];

    logic [X*OL-1:0] exp_out;
    logic            exp_dv;
    logic            exp_idle;
    int              exp_sat;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, want);
        end
    endtask

    task automatic drive();
        for (int j = 0; j < X; j++) begin
            bias_in[j*BL +: BL] = BL'(b_drv[j]);
            psum_in[j*AL +: AL] = AL'(p_drv[j]);
        end
    endtask

    function automatic int rnd(input int amp);
        return int'($urandom_range(0, 2 * amp - 1)) - amp;
    endfunction

    // Reference: each beat's result is computed with plain integer arithmetic when it is
    // accepted and becomes visible two edges later (the third cycle counting the input cycle).
    task automatic tick();
        res_t   r;
        longint s, v;
        int     sh, base;
        @(posedge clk);
        cyc++;
        if (rst) begin
            pend.delete();
            exp_out = '0;
            exp_dv  = 1'b0;
            exp_sat = 0;
            exp_idle = 1'b1;
            for (int j = 0; j < X; j++) bias_m[j] = 0;
        end else begin
            if (psum_valid) begin
                r.clips = 0;
                r.data  = '0;
                sh = int'(out_shift);
                for (int j = 0; j < X; j++) begin
                    s = longint'(p_drv[j]) + longint'(bias_m[j]);
                    v = (sh == 0) ? s : ((s + (longint'(1) <<< (sh - 1))) >>> sh);
                    if (v > 127) begin
                        v = 127;
                        r.clips++;
                    end else if (v < -128) begin
                        v = -128;
                        r.clips++;
                    end
                    if (relu_en && v < 0) v = 0;
                    r.data[j*OL +: OL] = OL'(v);
                end
                pend[cyc + 2] = r;
            end
            exp_dv = pend.exists(cyc);
            exp_idle = !(exp_dv || pend.exists(cyc + 1) || pend.exists(cyc + 2));
            base = bias_en ? 0 : exp_sat;
            if (exp_dv) begin
                exp_out = pend[cyc].data;
                base += pend[cyc].clips;
                pend.delete(cyc);
            end
            exp_sat = (base > 65535) ? 65535 : base;
            if (bias_en) begin
                for (int j = 0; j < X; j++) bias_m[j] = b_drv[j];
            end
        end
        @(negedge clk);
        if (data_valid === 1'b1) dv_seen++;
        chk("data_valid", 128'(data_valid), 128'(exp_dv));
        chk("data_out", 128'(data_out), 128'(exp_out));
        chk("sat_count", 128'(sat_count), 128'(exp_sat));
        chk("idle", 128'(idle), 128'(exp_idle));
    endtask

    task automatic set_uniform(input int b, input int p);
        for (int j = 0; j < X; j++) begin
            b_drv[j] = b;
            p_drv[j] = p;
        end
        drive();
    endtask

    vec_t tbl[12];
    logic [7:0]      e8;
    logic [X*OL-1:0] want;

    initial begin
        tbl[0]  = '{5,    100,  0,  1'b0, 105,  0};
        tbl[1]  = '{0,    -300, 1,  1'b0, -128, 16};
        tbl[2]  = '{0,    -300, 1,  1'b1, 0,    16};
        tbl[3]  = '{0,    6,    2,  1'b0, 2,    0};
        tbl[4]  = '{0,    -6,   2,  1'b0, -1,   0};
        tbl[5]  = '{0,    5,    2,  1'b0, 1,    0};
        tbl[6]  = '{1000, 500,  4,  1'b0, 94,   0};
        tbl[7]  = '{0,    100,  0,  1'b1, 100,  0};
        tbl[8]  = '{0,    200,  0,  1'b0, 127,  16};
        tbl[9]  = '{0,    -1,   31, 1'b0, 0,    0};
        tbl[10] = '{0,    -128, 0,  1'b1, 0,    0};
        tbl[11] = '{0,    255,  1,  1'b0, 127,  16};

        rst = 1'b1; bias_en = 1'b0; psum_valid = 1'b0; out_shift = '0; relu_en = 1'b0;
        exp_out = '0; exp_dv = 1'b0; exp_sat = 0; exp_idle = 1'b1;
        set_uniform(0, 0);
        tick(); tick();
        chk("reset_idle", 128'(idle), 128'(1));
        rst = 1'b0;
        tick();

        // Constant table: load bias, one beat, exact 3-cycle latency.
        for (int i = 0; i < 12; i++) begin
            set_uniform(tbl[i].bias, 0);
            bias_en = 1'b1;
            tick();
            bias_en = 1'b0;
            set_uniform(tbl[i].bias, tbl[i].psum);
            psum_valid = 1'b1; out_shift = 5'(tbl[i].shift); relu_en = tbl[i].relu;
            tick();
            psum_valid = 1'b0;
            tick();
            chk("tbl_early", 128'(data_valid), 128'(0));
            tick();
            e8   = 8'(tbl[i].exp);
            want = {X{e8}};
            chk("tbl_valid", 128'(data_valid), 128'(1));
            chk("tbl_data", 128'(data_out), 128'(want));
            chk("tbl_sat", 128'(sat_count), 128'(tbl[i].sat));
        end

        // bias_en coincident with a beat: that beat uses the old bias.
        set_uniform(3, 0); bias_en = 1'b1; relu_en = 1'b0; out_shift = '0;
        tick();
        bias_en = 1'b0; set_uniform(3, 200); psum_valid = 1'b1;
        tick();
        psum_valid = 1'b0;
        tick(); tick();
        chk("pre_sat", 128'(sat_count), 128'(16));
        set_uniform(10, 1); bias_en = 1'b1; psum_valid = 1'b1;
        tick();
        bias_en = 1'b0;
        tick();
        psum_valid = 1'b0;
        tick();
        e8 = 8'd4; want = {X{e8}};
        chk("coinc_old_bias", 128'(data_out), 128'(want));
        chk("coinc_sat_clr", 128'(sat_count), 128'(0));
        tick();
        e8 = 8'd11; want = {X{e8}};
        chk("coinc_new_bias", 128'(data_out), 128'(want));

        // 20 back-to-back beats, shift changes at beat 10.
        for (int j = 0; j < X; j++) b_drv[j] = rnd(4096);
        drive(); bias_en = 1'b1;
        tick();
        bias_en = 1'b0;
        dv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < X; j++) p_drv[j] = rnd(8192);
            drive();
            psum_valid = 1'b1;
            out_shift = (i < 10) ? 5'd3 : 5'd7;
            relu_en = 1'($urandom_range(0, 1));
            tick();
        end
        psum_valid = 1'b0; out_shift = 5'd0;
        tick(); tick();
        chk("b2b_count", 128'(dv_seen), 128'(20));
        chk("b2b_busy", 128'(idle), 128'(0));
        tick();
        chk("b2b_idle_after", 128'(idle), 128'(1));

        // Reset with two beats in flight.
        set_uniform(0, 500); psum_valid = 1'b1;
        tick();
        set_uniform(0, 40);
        tick(); tick();
        psum_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_valid", 128'(data_valid), 128'(0));
        chk("rst_data", 128'(data_out), 128'(0));
        chk("rst_sat", 128'(sat_count), 128'(0));
        chk("rst_idle", 128'(idle), 128'(1));
        rst = 1'b0;
        dv_seen = 0;
        tick(); tick(); tick();
        chk("rst_no_ghost", 128'(dv_seen), 128'(0));

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            int amp;
            rst     = ($urandom_range(0, 99) == 0);
            bias_en = ($urandom_range(0, 9) == 0);
            amp = ($urandom_range(0, 1) == 0) ? 512 : 524288;
            for (int j = 0; j < X; j++) begin
                b_drv[j] = rnd(amp);
                p_drv[j] = rnd(amp);
            end
            drive();
            psum_valid = ($urandom_range(0, 2) != 0);
            out_shift  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                      : 5'($urandom_range(0, 8));
            relu_en    = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b0; bias_en = 1'b0; psum_valid = 1'b0;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
